// File: rtl/instr_prefetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_prefetch_queue_if                                      |
// | Description : Memory read bus, instruction-register handshake and          |
// |               redirect signals of the instruction prefetch queue.          |
// |               master = prefetch queue side, slave = memory/decode side.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_pop;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fetch_err;

    modport master (
        output mem_rd_req, mem_addr, ir_valid, ir_data, ir_pc, fetch_err,
        input  mem_rd_valid, mem_rd_data, ir_pop, redirect, redirect_pc
    );

    modport slave (
        input  mem_rd_req, mem_addr, ir_valid, ir_data, ir_pc, fetch_err,
        output mem_rd_valid, mem_rd_data, ir_pop, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_prefetch_queue                                         |
// | Description : Instruction fetch front end. Issues sequential word reads    |
// |               ahead of execution (one outstanding), buffers words with     |
// |               their PCs in a DEPTH-entry FIFO, flushes on redirect.        |
// |               Optional macro PFQ_BOUND_CHECK_EN: refuse to fetch at or     |
// |               beyond MEM_WORDS and raise sticky fetch_err instead.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instr_prefetch_queue #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                MEM_WORDS = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    instr_prefetch_queue_if.master bus
);
    localparam int                  c_PTR_W      = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_DEPTH      = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]    c_DEPTH_M1   = (c_PTR_W+1)'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [ADDR_W:0]     c_MEM_WORDS  = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [ADDR_W-1:0]   c_PC_ONE     = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_fetch_pc, w_fetch_pc_next;
    logic               r_discard, w_discard_next;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_in_range;
    logic [ADDR_W-1:0]  w_pc_plus1;
    logic [ADDR_W-1:0]  w_pc_inc;

    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [ADDR_W-1:0]  r_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_ap;

    // A pop only counts when there is a head and no redirect overrides it.
    assign w_pop      = bus.ir_pop && (r_count != '0) && !bus.redirect;
    // Occupancy once this cycle's pop is taken; the credit decisions use it.
    assign w_count_ap = r_count - {{c_PTR_W{1'b0}}, w_pop};
    assign w_pc_plus1 = r_fetch_pc + c_PC_ONE;

`ifdef PFQ_BOUND_CHECK_EN
    logic w_err_set;
    logic r_fetch_err;

    // Out-of-range PCs must stay visible so the bound check can catch them.
    assign w_pc_inc   = w_pc_plus1;
    assign w_in_range = ({1'b0, r_fetch_pc} < c_MEM_WORDS);

    // Sticky bound error, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_err <= 1'b0;
        end else if (w_err_set) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign bus.fetch_err = r_fetch_err;
`else
    // Wrap inside the instruction memory (MEM_WORDS-1 -> 0).
    assign w_pc_inc      = ADDR_W'({1'b0, w_pc_plus1} % c_MEM_WORDS);
    assign w_in_range    = 1'b1;
    assign bus.fetch_err = 1'b0;
`endif

    // Fetch FSM state, fetch PC and stale-response flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_discard  <= w_discard_next;
        end
    end

    // Next-state, request strobe and push decision; redirect overrides all.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_discard_next  = r_discard;
        w_req           = 1'b0;
        w_push          = 1'b0;
`ifdef PFQ_BOUND_CHECK_EN
        w_err_set       = 1'b0;
`endif
        if (bus.redirect) begin
            w_fetch_pc_next = bus.redirect_pc;
            if (r_state == S_WAIT) begin
                // A response arriving now is the stale one and is dropped here;
                // otherwise remember to drop it when it shows up.
                w_discard_next = !bus.mem_rd_valid;
                w_state_next   = bus.mem_rd_valid ? S_REQ : S_WAIT;
            end else begin
                // The request strobe is suppressed, so nothing is in flight.
                w_state_next = S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_count_ap < c_DEPTH) begin
                        if (w_in_range) begin
                            w_state_next = S_REQ;
                        end
`ifdef PFQ_BOUND_CHECK_EN
                        else begin
                            w_err_set = 1'b1;
                        end
`endif
                    end
                end
                S_REQ: begin
                    if (w_in_range) begin
                        w_req        = 1'b1;
                        w_state_next = S_WAIT;
                    end
`ifdef PFQ_BOUND_CHECK_EN
                    else begin
                        w_err_set    = 1'b1;
                        w_state_next = S_IDLE;
                    end
`endif
                end
                S_WAIT: begin
                    if (bus.mem_rd_valid) begin
                        if (r_discard) begin
                            w_discard_next = 1'b0;
                            w_state_next   = (w_count_ap < c_DEPTH) ? S_REQ : S_IDLE;
                        end else begin
                            // Slot is guaranteed by the credit check at issue time.
                            w_push          = 1'b1;
                            w_fetch_pc_next = w_pc_inc;
                            w_state_next    = (w_count_ap < c_DEPTH_M1) ? S_REQ : S_IDLE;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clock) begin
        if (reset || bus.redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_ap + {{c_PTR_W{1'b0}}, w_push};
        end
    end

    // FIFO storage: instruction word with the PC it was fetched from.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= bus.mem_rd_data;
            r_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign bus.mem_rd_req = w_req;
    assign bus.mem_addr   = r_fetch_pc;
    assign bus.ir_valid   = (r_count != '0);
    assign bus.ir_data    = r_data[r_rd_ptr];
    assign bus.ir_pc      = r_pc[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_prefetch_queue                                      |
// | Description : Self-checking bench for instr_prefetch_queue: directed       |
// |               scenarios plus randomized pop/redirect/latency traffic       |
// |               against a queue-level reference model.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instr_prefetch_queue;
    localparam int          DEPTH     = 4;
    localparam int          ADDR_W    = 16;
    localparam int          DATA_W    = 16;
    localparam int          MEM_WORDS = 32;
    localparam logic [15:0] RESET_PC  = 16'd0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    instr_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // kind: 0 live, 1 made stale by redirect, 2 issued before/at reset
    typedef struct {
        logic [15:0] addr;
        int          due;
        int          kind;
    } rsp_t;

    rsp_t        pend[$];
    logic [15:0] mq[$];
    logic [15:0] popped[$];
    logic [15:0] exp_fetch = RESET_PC;
    logic [15:0] last_req_addr = '0;
    bit          last_req = 0;
    bit          model_live = 0;
    int          cyc = 0;
    int          lat_fixed = 1;
    int          n_req = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a < MEM_WORDS) return 16'hA000 + a;
        return 16'hDEAD;
    endfunction

    function automatic logic [15:0] next_pc(input logic [15:0] pc);
        int unsigned v;
        v = (int'(pc) + 1) % 65536;
`ifndef PFQ_BOUND_CHECK_EN
        v = v % MEM_WORDS;
`endif
        return v[15:0];
    endfunction

    // One clock cycle: check the DUT against the model, drive inputs and the
    // memory response, then advance the model by what happens at the edge.
    task automatic tick(input bit pop, input bit redir, input logic [15:0] rpc, input bit rst);
        bit          have_rsp;
        bit          take_pop;
        rsp_t        rsp;
        logic [15:0] exp_prev;
        int          live;
        int          lat;
        @(negedge clock);
        if (model_live) begin
            check_eq("ir_valid", bus.ir_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check_eq("ir_pc", bus.ir_pc, mq[0]);
                check_eq("ir_data", bus.ir_data, mem_word(mq[0]));
            end
            check_eq("occupancy_le_depth", mq.size() <= DEPTH, 1);
`ifndef PFQ_BOUND_CHECK_EN
            check_eq("fetch_err_tied", bus.fetch_err, 0);
`endif
        end
        reset           = rst;
        bus.ir_pop      = pop;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        have_rsp        = 0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            rsp              = pend.pop_front();
            have_rsp         = 1;
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem_word(rsp.addr);
        end else begin
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = 16'($urandom);
        end
        #1;
        exp_prev = exp_fetch;
        lat      = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
        if (rst) begin
            foreach (pend[i]) pend[i].kind = 2;
            mq.delete();
            popped.delete();
            exp_fetch  = RESET_PC;
            n_req      = 0;
            last_req   = 0;
            model_live = 1;
            if (bus.mem_rd_req === 1'b1)
                pend.push_back('{addr: bus.mem_addr, due: cyc + lat, kind: 2});
        end else begin
            take_pop = pop && (mq.size() != 0) && !redir;
            if (take_pop) popped.push_back(mq.pop_front());
            if (have_rsp && !redir && rsp.kind == 0) begin
                mq.push_back(rsp.addr);
                exp_fetch = next_pc(rsp.addr);
            end
            if (redir) begin
                mq.delete();
                foreach (pend[i]) if (pend[i].kind == 0) pend[i].kind = 1;
                exp_fetch = rpc;
            end
            last_req = (bus.mem_rd_req === 1'b1);
            if (last_req) begin
                n_req++;
                last_req_addr = bus.mem_addr;
                live = 0;
                foreach (pend[i]) if (pend[i].kind != 2) live++;
                check_eq("one_outstanding", live, 0);
                check_eq("req_addr", bus.mem_addr, exp_prev);
`ifdef PFQ_BOUND_CHECK_EN
                check_eq("req_in_range", exp_prev < MEM_WORDS, 1);
`endif
                pend.push_back('{addr: bus.mem_addr, due: cyc + lat, kind: 0});
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 16'd0, 1);
    endtask

    task automatic run_until_req(input logic [15:0] addr, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(0, 0, 16'd0, 0);
            if (last_req && last_req_addr == addr) ok = 1;
        end
    endtask

    task automatic run_until_valid(input bit pop, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(pop, 0, 16'd0, 0);
            if (mq.size() != 0) ok = 1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.ir_pop       = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;

        // Fill with no pops: four requests, then stall while full.
        lat_fixed = 1;
        do_reset(3);
        @(posedge clock);
        #1;
        check_eq("rst_ir_valid", bus.ir_valid, 0);
        check_eq("rst_mem_rd_req", bus.mem_rd_req, 0);
        check_eq("rst_fetch_err", bus.fetch_err, 0);
        for (int i = 0; i < 16; i++) tick(0, 0, 16'd0, 0);
        check_eq("fill_req_count", n_req, 4);
        check_eq("fill_head_pc", bus.ir_pc, 0);
        check_eq("fill_head_data", bus.ir_data, 16'hA000);
        check_eq("fill_full_valid", bus.ir_valid, 1);

        // Drain with a pop every cycle: consecutive PCs, no gaps.
        popped.delete();
        for (int i = 0; i < 16; i++) tick(1, 0, 16'd0, 0);
        check_eq("drain_pop_count_ge6", popped.size() >= 6, 1);
        foreach (popped[i]) check_eq("drain_seq", popped[i], i);

        // Redirect while waiting for address 2: stale word dropped.
        lat_fixed = 3;
        do_reset(2);
        run_until_req(16'd2, 40, ok);
        check_eq("redir_saw_req2", ok, 1);
        tick(0, 1, 16'd9, 0);
        run_until_valid(0, 40, ok);
        check_eq("redir_valid_seen", ok, 1);
        check_eq("redir_ir_valid", bus.ir_valid, 1);
        check_eq("redir_ir_pc", bus.ir_pc, 9);
        check_eq("redir_ir_data", bus.ir_data, 16'hA009);

`ifndef PFQ_BOUND_CHECK_EN
        // Wrap at the top of instruction memory.
        lat_fixed = 0;
        do_reset(2);
        tick(0, 1, 16'd30, 0);
        popped.delete();
        for (int i = 0; i < 40; i++) tick(1, 0, 16'd0, 0);
        check_eq("wrap_count_ge4", popped.size() >= 4, 1);
        if (popped.size() >= 4) begin
            check_eq("wrap_pc0", popped[0], 30);
            check_eq("wrap_pc1", popped[1], 31);
            check_eq("wrap_pc2", popped[2], 0);
            check_eq("wrap_pc3", popped[3], 1);
        end
`else
        // Bound check: stop at MEM_WORDS, sticky error, resume on redirect.
        lat_fixed = 0;
        do_reset(2);
        tick(0, 1, 16'd30, 0);
        popped.delete();
        for (int i = 0; i < 40; i++) tick(1, 0, 16'd0, 0);
        check_eq("bound_count", popped.size(), 2);
        if (popped.size() >= 2) begin
            check_eq("bound_pc0", popped[0], 30);
            check_eq("bound_pc1", popped[1], 31);
        end
        check_eq("bound_err_set", bus.fetch_err, 1);
        tick(0, 1, 16'd0, 0);
        popped.delete();
        for (int i = 0; i < 20; i++) tick(1, 0, 16'd0, 0);
        check_eq("bound_resume_ge1", popped.size() >= 1, 1);
        if (popped.size() >= 1) check_eq("bound_resume_pc", popped[0], 0);
        check_eq("bound_err_sticky", bus.fetch_err, 1);
`endif

        // Reset during WAIT with a slow memory: late response ignored.
        lat_fixed = 3;
        do_reset(2);
        run_until_req(16'd2, 40, ok);
        check_eq("rstwait_saw_req2", ok, 1);
        tick(0, 0, 16'd0, 0);
        tick(0, 0, 16'd0, 1);
        @(posedge clock);
        #1;
        check_eq("rstwait_ir_valid", bus.ir_valid, 0);
        check_eq("rstwait_mem_rd_req", bus.mem_rd_req, 0);
        check_eq("rstwait_fetch_err", bus.fetch_err, 0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick(0, 0, 16'd0, 0);
            if (last_req) ok = 1;
        end
        check_eq("rstwait_req_seen", ok, 1);
        check_eq("rstwait_first_addr", last_req_addr, RESET_PC);
        run_until_valid(0, 20, ok);
        check_eq("rstwait_valid_seen", ok, 1);
        check_eq("rstwait_head_pc", bus.ir_pc, RESET_PC);
        check_eq("rstwait_head_data", bus.ir_data, 16'hA000 + RESET_PC);

        // Randomized traffic: pops, redirects and memory latency 1..3.
        lat_fixed = 0;
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 10) < 6, ($urandom % 20) == 0,
                 16'($urandom_range(0, MEM_WORDS - 1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
